// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - funct3 codes, FSM state encoding and access legality check
package mem_access_pkg;

    // Load encodings of funct3
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // Store encodings share the low codes with the signed loads
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True when funct3 is defined for the access type and addr is naturally aligned
    function automatic logic access_legal(input logic is_store,
                                          input logic [2:0] f3,
                                          input logic [1:0] lo);
        logic ok;
        ok = 1'b0;
        if (is_store) begin
            case (f3)
                SB:      ok = 1'b1;
                SH:      ok = ~lo[0];
                SW:      ok = (lo == 2'b00);
                default: ok = 1'b0;
            endcase
        end else begin
            case (f3)
                LB, LBU: ok = 1'b1;
                LH, LHU: ok = ~lo[0];
                LW:      ok = (lo == 2'b00);
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - byte-lane enables, store replication and load extension
module mem_align
    import mem_access_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Select the addressed lane, then mask/replicate/extend by access width
    always_comb begin
        be        = 4'b0000;
        wdata_rep = 32'h0;
        rdata_ext = 32'h0;

        case (addr)
            2'd0:    lane_b = mem_rdata[7:0];
            2'd1:    lane_b = mem_rdata[15:8];
            2'd2:    lane_b = mem_rdata[23:16];
            default: lane_b = mem_rdata[31:24];
        endcase
        lane_h = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        // SB/SH/SW decode through the LB/LH/LW items since the codes coincide
        case (funct3)
            LB: begin
                be        = 4'b0001 << addr;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{lane_b[7]}}, lane_b};
            end
            LBU: begin
                be        = 4'b0001 << addr;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {24'h0, lane_b};
            end
            LH: begin
                be        = 4'b0011 << {addr[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{lane_h[15]}}, lane_h};
            end
            LHU: begin
                be        = 4'b0011 << {addr[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {16'h0, lane_h};
            end
            LW: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = mem_rdata;
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = 32'h0;
                rdata_ext = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store sequencer with alignment check and ack timeout
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
)
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err_misalign,
    output logic        err_timeout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    state_t        state;
    state_t        state_next;

    logic          lat_we;
    logic [2:0]    lat_funct3;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_wdata;
    logic [CW-1:0] cnt;

    logic          req_legal;
    logic          cnt_expired;
    logic [3:0]    al_be;
    logic [31:0]   al_wdata_rep;
    logic [31:0]   al_rdata_ext;

    // Lane steering works from the latched request so the bus stays stable in REQ
    mem_align u_align (
        .funct3    (lat_funct3),
        .addr      (lat_addr[1:0]),
        .wdata     (lat_wdata),
        .mem_rdata (mem_rdata),
        .be        (al_be),
        .wdata_rep (al_wdata_rep),
        .rdata_ext (al_rdata_ext)
    );

    assign req_legal   = access_legal(we, funct3, addr[1:0]);
    assign cnt_expired = (cnt == CNT_LAST);

    // Bus outputs only carry a request while in REQ; rejected accesses never reach memory
    assign mem_addr  = {lat_addr[31:2], 2'b00};
    assign mem_we    = mem_req & lat_we;
    assign mem_be    = mem_req ? al_be : 4'b0000;
    assign mem_wdata = mem_we ? al_wdata_rep : 32'h0;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-state control outputs; an ack on the last count cycle beats the timeout
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        mem_req    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = req_legal ? ST_REQ : ST_DONE;
                end
            end
            ST_REQ: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                if (mem_ack || cnt_expired) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Request latch, result/error capture and the REQ-cycle counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            lat_we       <= 1'b0;
            lat_funct3   <= 3'b000;
            lat_addr     <= 32'h0;
            lat_wdata    <= 32'h0;
            cnt          <= '0;
            rdata        <= 32'h0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        lat_we       <= we;
                        lat_funct3   <= funct3;
                        lat_addr     <= addr;
                        lat_wdata    <= wdata;
                        err_misalign <= ~req_legal;
                        err_timeout  <= 1'b0;
                        rdata        <= 32'h0;
                        cnt          <= '0;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        if (!lat_we) begin
                            rdata <= al_rdata_ext;
                        end
                        cnt <= '0;
                    end else if (cnt_expired) begin
                        err_timeout <= 1'b1;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

    localparam int TO = 16;

    logic        CLK;
    logic        RST;
    logic        start;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        err_misalign;
    logic        err_timeout;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int tests;
    int fails;

    typedef struct {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] mrd;
        int          aw;    // ack after this many wait cycles; -1 = never
        logic [3:0]  be;
        logic [31:0] wrep;
        logic [31:0] rd;
        logic        mis;
        logic        tmo;
        int          lat;   // cycles from start to done
    } vec_t;

    vec_t vecs[13];

    mem_access_unit #(.ACK_TIMEOUT(TO)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .start        (start),
        .we           (we),
        .funct3       (funct3),
        .addr         (addr),
        .wdata        (wdata),
        .busy         (busy),
        .done         (done),
        .rdata        (rdata),
        .err_misalign (err_misalign),
        .err_timeout  (err_timeout),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: access size, legality and lane arithmetic from the rules
    function automatic vec_t model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [31:0] mrd, input int aw);
        vec_t   v;
        int     f;
        int     nbytes;
        int     off;
        bit     valid;
        longint span;
        longint val;
        v = '{w, f3, a, wd, mrd, aw, 4'b0, 32'h0, 32'h0, 1'b0, 1'b0, 0};
        f = int'(f3);
        off = int'(a[1:0]);
        nbytes = (f % 4 == 0) ? 1 : ((f % 4 == 1) ? 2 : 4);
        valid = w ? (f <= 2) : (f != 3 && f != 6 && f != 7);
        if (!valid || (off % nbytes) != 0) begin
            v.mis = 1'b1;
            v.lat = 1;
            return v;
        end
        v.be = 4'(((1 << nbytes) - 1) << off);
        if (nbytes == 1)      v.wrep = (wd & 32'hFF) * 32'h01010101;
        else if (nbytes == 2) v.wrep = (wd & 32'hFFFF) * 32'h00010001;
        else                  v.wrep = wd;
        if (aw < 0 || aw >= TO) begin
            v.tmo = 1'b1;
            v.lat = TO + 1;
        end else begin
            v.lat = aw + 2;
            if (!w) begin
                span = longint'(1) << (8 * nbytes);
                val  = (longint'(mrd) >> (8 * off)) % span;
                if (f < 4 && nbytes < 4 && val >= span / 2) val = val - span;
                v.rd = val[31:0];
            end
        end
        return v;
    endfunction

    // Issue one access, act as the memory, and check bus, latency and results
    task automatic run_access(input string nm, input vec_t v, input bit noise);
        int          done_at;
        int          bad;
        bit          first;
        logic [31:0] s_addr;
        logic [31:0] s_wdata;
        logic [3:0]  s_be;
        logic        s_we;
        done_at = -1;
        bad     = 0;
        first   = 1'b1;
        s_addr  = 32'h0;
        s_wdata = 32'h0;
        s_be    = 4'h0;
        s_we    = 1'b0;
        @(negedge CLK);
        start = 1'b1; we = v.w; funct3 = v.f3; addr = v.a; wdata = v.wd; mem_rdata = v.mrd;
        mem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge CLK);
        start = 1'b0; we = ~v.w; funct3 = ~v.f3; addr = ~v.a; wdata = ~v.wd; mem_ack = 1'b0;
        for (int c = 1; c <= TO + 8; c++) begin
            if (done) begin
                done_at = c;
                break;
            end
            if (first) begin
                chk({nm, "_req"},   {31'h0, mem_req}, 32'h1);
                chk({nm, "_addr"},  mem_addr, {v.a[31:2], 2'b00});
                chk({nm, "_be"},    {28'h0, mem_be}, {28'h0, v.be});
                chk({nm, "_we"},    {31'h0, mem_we}, {31'h0, v.w});
                if (v.w) chk({nm, "_wdata"}, mem_wdata, v.wrep);
                s_addr = mem_addr; s_wdata = mem_wdata; s_be = mem_be; s_we = mem_we;
                first = 1'b0;
            end else if (mem_addr !== s_addr || mem_wdata !== s_wdata || mem_be !== s_be ||
                         mem_we !== s_we || mem_req !== 1'b1 || busy !== 1'b1) begin
                bad++;
            end
            mem_ack = (v.aw >= 0 && c == v.aw + 1);
            @(negedge CLK);
            mem_ack = 1'b0;
        end
        chk({nm, "_latency"}, 32'(done_at), 32'(v.lat));
        if (v.lat > 1) chk({nm, "_held"}, 32'(bad), 32'h0);
        chk({nm, "_req_at_done"}, {31'h0, mem_req}, 32'h0);
        chk({nm, "_misalign"}, {31'h0, err_misalign}, {31'h0, v.mis});
        chk({nm, "_timeout"},  {31'h0, err_timeout},  {31'h0, v.tmo});
        chk({nm, "_rdata"},    rdata, v.rd);
        @(negedge CLK);
        chk({nm, "_idle"}, {30'h0, done, busy}, 32'h0);
        chk({nm, "_rdata_hold"}, rdata, v.rd);
    endtask

    initial begin
        int ndone;
        int sel;
        int aw;
        vec_t rv;
        logic [31:0] ra;
        tests = 0;
        fails = 0;
        RST = 1'b1; start = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h0;
        wdata = 32'h5555AAAA; mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;

        // Reset wins over a simultaneous start and ack
        repeat (2) @(negedge CLK);
        chk("rst_busy",   {31'h0, busy}, 32'h0);
        chk("rst_done",   {31'h0, done}, 32'h0);
        chk("rst_req",    {31'h0, mem_req}, 32'h0);
        chk("rst_we",     {31'h0, mem_we}, 32'h0);
        chk("rst_be",     {28'h0, mem_be}, 32'h0);
        chk("rst_errs",   {30'h0, err_misalign, err_timeout}, 32'h0);
        chk("rst_rdata",  rdata, 32'h0);
        start = 1'b0; mem_ack = 1'b0; RST = 1'b0;

        //            w     f3      addr          wdata         mem_rdata     aw  be       wrep          rdata         mis   tmo   lat
        vecs[0]  = '{1'b0, 3'b000, 32'h00001003, 32'h00000000, 32'h80FFFFFF, 2,  4'b1000, 32'h00000000, 32'hFFFFFF80, 1'b0, 1'b0, 4};
        vecs[1]  = '{1'b1, 3'b001, 32'h00002002, 32'h1234ABCD, 32'h00000000, 0,  4'b1100, 32'hABCDABCD, 32'h00000000, 1'b0, 1'b0, 2};
        vecs[2]  = '{1'b0, 3'b010, 32'h00000001, 32'h00000000, 32'h00000000, 0,  4'b0000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1};
        vecs[3]  = '{1'b0, 3'b101, 32'h00000002, 32'h00000000, 32'h12345678, -1, 4'b1100, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 17};
        vecs[4]  = '{1'b0, 3'b001, 32'h00000002, 32'h00000000, 32'h80011234, 1,  4'b1100, 32'h00000000, 32'hFFFF8001, 1'b0, 1'b0, 3};
        vecs[5]  = '{1'b0, 3'b100, 32'h00000001, 32'h00000000, 32'h00009A00, 0,  4'b0010, 32'h00000000, 32'h0000009A, 1'b0, 1'b0, 2};
        vecs[6]  = '{1'b1, 3'b000, 32'h00000003, 32'hAABBCC5E, 32'hFFFFFFFF, 3,  4'b1000, 32'h5E5E5E5E, 32'h00000000, 1'b0, 1'b0, 5};
        vecs[7]  = '{1'b1, 3'b010, 32'h00000000, 32'hDEADBEEF, 32'h00000000, 0,  4'b1111, 32'hDEADBEEF, 32'h00000000, 1'b0, 1'b0, 2};
        vecs[8]  = '{1'b0, 3'b010, 32'h00000010, 32'h00000000, 32'hCAFEF00D, 15, 4'b1111, 32'h00000000, 32'hCAFEF00D, 1'b0, 1'b0, 17};
        vecs[9]  = '{1'b1, 3'b011, 32'h00000000, 32'h11111111, 32'h00000000, 0,  4'b0000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1};
        vecs[10] = '{1'b0, 3'b110, 32'h00000000, 32'h00000000, 32'h00000000, 0,  4'b0000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1};
        vecs[11] = '{1'b1, 3'b001, 32'h00000001, 32'h22222222, 32'h00000000, 0,  4'b0000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1};
        vecs[12] = '{1'b0, 3'b000, 32'h00000000, 32'h00000000, 32'h0000007F, 0,  4'b0001, 32'h00000000, 32'h0000007F, 1'b0, 1'b0, 2};

        for (int i = 0; i < 13; i++) begin
            run_access($sformatf("vec%0d", i), vecs[i], 1'b0);
        end

        // A second start while busy is dropped; acks outside REQ are ignored
        @(negedge CLK);
        start = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h20; mem_rdata = 32'h11223344;
        @(negedge CLK);
        start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 12; c++) begin
            if (done) ndone++;
            if (c == 3) chk("busy_addr", mem_addr, 32'h20);
            start = (c == 2);
            if (c == 2) begin we = 1'b1; addr = 32'h44; end
            mem_ack = (c == 3) || (c >= 6 && c <= 8);
            @(negedge CLK);
        end
        start = 1'b0; mem_ack = 1'b0;
        chk("busy_done_pulses", 32'(ndone), 32'h1);
        chk("busy_rdata", rdata, 32'h11223344);
        chk("busy_idle", {31'h0, busy}, 32'h0);

        // Reset in the third REQ cycle drops the request with no done pulse
        @(negedge CLK);
        start = 1'b1; we = 1'b0; funct3 = 3'b101; addr = 32'h4;
        @(negedge CLK);
        start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin
                chk("rstreq_req_c3", {31'h0, mem_req}, 32'h1);
                RST = 1'b1;
            end
            @(negedge CLK);
        end
        chk("rstreq_req", {31'h0, mem_req}, 32'h0);
        chk("rstreq_busy", {31'h0, busy}, 32'h0);
        chk("rstreq_done", {31'h0, done}, 32'h0);
        RST = 1'b0;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            if (done || busy) ndone++;
            @(negedge CLK);
        end
        chk("rstreq_quiet", 32'(ndone), 32'h0);

        // Randomised accesses against the reference model
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      aw = -1;
            else if (sel == 1) aw = 15;
            else if (sel == 2) aw = 14;
            else               aw = $urandom_range(0, 4);
            ra = $urandom;
            if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
            rv = model(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra,
                       $urandom, $urandom, aw);
            run_access($sformatf("rnd%0d", i), rv, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
